// File: rtl/frame_pkg.sv
// Shared definitions for the frame serializer: default frame width, one-hot FSM
// encodings and a constant-evaluable clog2 used for pointer/counter widths.
package frame_pkg;

  localparam int FRAME_BITS_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'b01;
  localparam logic [1:0] ST_SHIFT = 2'b10;

  // Never returns less than 1 so a 2-entry FIFO still gets a 1-bit pointer.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with wrapping pointers and an occupancy count.
// Pushes while full and pops while empty are ignored.
module frame_fifo
  import frame_pkg::*;
#(
  parameter int WIDTH = FRAME_BITS_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial front end: FIFO-buffered frames shifted out MSB-first with
// frame boundary flags. Define FRAME_COUNT_EN to add the frames_sent counter.
module frame_serializer
  import frame_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FRAME_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  ser_bit,
  output logic                  ser_valid,
  output logic                  ser_first,
  output logic                  ser_last
`ifdef FRAME_COUNT_EN
  ,
  output logic [15:0]           frames_sent
`endif
);
  localparam int BW = clog2(FRAME_BITS);
  localparam int CW = clog2(DEPTH) + 1;

  logic                  full, empty, pop, shifting_n;
  logic [CW-1:0]         count;
  logic [FRAME_BITS-1:0] rdata, shreg, shreg_n;
  logic [BW-1:0]         bitcnt, bitcnt_n;
  logic [1:0]            state, state_n;

  assign in_ready = (count != CW'(DEPTH));

  frame_fifo #(.WIDTH(FRAME_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid & ~full),
    .pop   (pop),
    .wdata (in_data),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shreg_n  = rdata;
          bitcnt_n = BW'(FRAME_BITS - 1);
          state_n  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bitcnt == '0) begin
          // Reload on the last bit keeps consecutive frames gap-free.
          if (!empty) begin
            pop      = 1'b1;
            shreg_n  = rdata;
            bitcnt_n = BW'(FRAME_BITS - 1);
          end else begin
            state_n  = ST_IDLE;
          end
        end else begin
          shreg_n  = shreg << 1;
          bitcnt_n = bitcnt - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign shifting_n = (state_n == ST_SHIFT);

  // Flags are computed from next-state values so every ser_* is a plain flop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
      ser_valid <= shifting_n;
      ser_bit   <= shifting_n & shreg_n[FRAME_BITS-1];
      ser_first <= shifting_n & (bitcnt_n == BW'(FRAME_BITS - 1));
      ser_last  <= shifting_n & (bitcnt_n == '0);
    end
  end

`ifdef FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset)        frames_sent <= '0;
    else if (ser_last) frames_sent <= frames_sent + 16'd1;
  end
`endif

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: stimulus queues expected serial bits,
// a negedge monitor pops and compares whenever ser_valid is high.
module tb_frame_serializer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_data = '0;
  logic       in_ready, ser_bit, ser_valid, ser_first, ser_last;
`ifdef FRAME_COUNT_EN
  logic [15:0] frames_sent;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q [$];  // {bit, first, last}

  always #5 clk = ~clk;

  frame_serializer #(.FRAME_BITS(3), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_last  (ser_last)
`ifdef FRAME_COUNT_EN
    ,
    .frames_sent (frames_sent)
`endif
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid serial bit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ser_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_bit: got bit=%b first=%b last=%b want none at %0t",
                 ser_bit, ser_first, ser_last, $time);
      end else begin
        chk("ser_out", {13'd0, ser_bit, ser_first, ser_last}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input logic [2:0] d, input int nexp, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got in_ready=0 want 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 2; i >= 0; i--)
      if ((2 - i) < nexp) exp_q.push_back({d[i], i == 2, i == 0});
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((exp_q.size() != 0 || ser_valid !== 1'b0) && c < 100);
    chk(name, 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    int w;
    logic [2:0] f6 [5];
    f6[0] = 3'b100; f6[1] = 3'b011; f6[2] = 3'b111; f6[3] = 3'b000; f6[4] = 3'b101;

    // 1: reset and idle
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_outputs", {11'd0, in_ready, ser_valid, ser_bit, ser_first, ser_last}, 16'b10000);
    end
    @(posedge clk); #1;

    // 2: single frame latency
    push(3'b101, 3, w);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t2_valid_timing", {15'd0, ser_valid}, (c >= 1 && c <= 3) ? 16'd1 : 16'd0);
    end
    drain("t2_drain");

    // 3: back-to-back frames without a gap
    push(3'b110, 3, w);
    push(3'b011, 3, w);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t3_no_gap", {15'd0, ser_valid}, 16'd1);
    end
    @(negedge clk);
    chk("t3_end", {15'd0, ser_valid}, 16'd0);
    drain("t3_drain");

    // 4: FIFO fills; 7th frame stalls until a pop frees a slot
    for (int i = 0; i < 7; i++) begin
      push(3'(i + 1), 3, w);
      chk("t4_stall_cycles", 16'(w), (i == 6) ? 16'd2 : 16'd0);
      if (i == 5) chk("t4_full_ready", {15'd0, in_ready}, 16'd0);
    end
    drain("t4_drain");

    // 5: reset mid-frame drops the frame and the queued ones
    push(3'b111, 2, w);
    push(3'b010, 0, w);
    push(3'b001, 0, w);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_after_reset", {14'd0, ser_valid, in_ready}, 16'b01);
    repeat (12) @(negedge clk);
    chk("t5_queue", 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;

    // 6: five frames, then optional counter check
    for (int i = 0; i < 5; i++) push(f6[i], 3, w);
    drain("t6_drain");
`ifdef FRAME_COUNT_EN
    chk("t6_frames_sent", frames_sent, 16'd5);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("t6_frames_reset", frames_sent, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
